// File: rtl/bottle_fill_ctrl_if.sv
// Signal bundle between the filling-line sequencer and its host.
//   start, pause, clear, pill_in       : control and sensor inputs to the sequencer
//   pills_per_bottle, bottle_target    : batch settings, latched by the sequencer on start
//   valve_open, conveyor_run           : actuator drives from the sequencer
//   pill_cnt, bottle_cnt               : progress counters from the sequencer
//   allFull, cfg_err                   : batch-complete and bad-setting flags
// The master modport is the host side; the slave modport is the sequencer.
interface bottle_fill_ctrl_if #(
    parameter int unsigned PILL_W   = 8,
    parameter int unsigned BOTTLE_W = 8
);
    logic                start;
    logic                pause;
    logic                clear;
    logic                pill_in;
    logic [PILL_W-1:0]   pills_per_bottle;
    logic [BOTTLE_W-1:0] bottle_target;
    logic                valve_open;
    logic                conveyor_run;
    logic [PILL_W-1:0]   pill_cnt;
    logic [BOTTLE_W-1:0] bottle_cnt;
    logic                allFull;
    logic                cfg_err;

    modport master (
        output start, pause, clear, pill_in, pills_per_bottle, bottle_target,
        input  valve_open, conveyor_run, pill_cnt, bottle_cnt, allFull, cfg_err
    );

    modport slave (
        input  start, pause, clear, pill_in, pills_per_bottle, bottle_target,
        output valve_open, conveyor_run, pill_cnt, bottle_cnt, allFull, cfg_err
    );
endinterface

// File: rtl/bottle_fill_ctrl.sv
// Filling-line sequencer: counts pills into each bottle, indexes the conveyor
// between bottles and raises allFull once the batch is complete.
// Ports:
//   CLK    : system clock (100 kHz)
//   RST_N  : asynchronous active-low reset
//   bus    : slave side of bottle_fill_ctrl_if (controls, settings, drives, counters, flags)
// All outputs are registered and computed from the next state, so they change
// on the same edge as the state register and have no combinational input paths.
module bottle_fill_ctrl #(
    parameter int unsigned PILL_W     = 8,
    parameter int unsigned BOTTLE_W   = 8,
    parameter int unsigned ADV_CYCLES = 50000,
    parameter int unsigned ADV_W      = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    bottle_fill_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FILL    = 2'd1;
    localparam logic [1:0] ADVANCE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [ADV_W-1:0] ADV_LOAD = ADV_W'(ADV_CYCLES - 1);

    logic [1:0]          state_q, state_d;
    logic [2:0]          pill_sync_q;
    logic                pill_edge;
    logic [PILL_W-1:0]   pill_cnt_q, pill_cnt_d;
    logic [BOTTLE_W-1:0] bottle_cnt_q, bottle_cnt_d;
    logic [PILL_W-1:0]   ppb_q, ppb_d;
    logic [BOTTLE_W-1:0] tgt_q, tgt_d;
    logic [ADV_W-1:0]    timer_q, timer_d;
    logic                cfg_err_q, cfg_err_d;
    logic                valve_q, valve_d;
    logic                conv_q, conv_d;
    logic                full_q, full_d;

    // [0],[1] form the synchroniser; [2] is the previous synchronised value.
    assign pill_edge = pill_sync_q[1] & ~pill_sync_q[2];

    always_comb begin
        state_d      = state_q;
        pill_cnt_d   = pill_cnt_q;
        bottle_cnt_d = bottle_cnt_q;
        ppb_d        = ppb_q;
        tgt_d        = tgt_q;
        timer_d      = timer_q;
        cfg_err_d    = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.pills_per_bottle == '0 || bus.bottle_target == '0) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        ppb_d        = bus.pills_per_bottle;
                        tgt_d        = bus.bottle_target;
                        cfg_err_d    = 1'b0;
                        pill_cnt_d   = '0;
                        bottle_cnt_d = '0;
                        state_d      = FILL;
                    end
                end
            end
            FILL: begin
                // Pills already falling are counted even while paused.
                if (pill_edge) begin
                    // Targets are non-zero here, so comparing against target-1
                    // closes the bottle before the counter could overflow.
                    if (pill_cnt_q == ppb_q - PILL_W'(1)) begin
                        pill_cnt_d   = '0;
                        bottle_cnt_d = bottle_cnt_q + BOTTLE_W'(1);
                        if (bottle_cnt_q == tgt_q - BOTTLE_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = ADVANCE;
                            timer_d = ADV_LOAD;
                        end
                    end else begin
                        pill_cnt_d = pill_cnt_q + PILL_W'(1);
                    end
                end
            end
            ADVANCE: begin
                if (!bus.pause) begin
                    if (timer_q == '0) begin
                        state_d = FILL;
                    end else begin
                        timer_d = timer_q - ADV_W'(1);
                    end
                end
            end
            DONE: begin
                // Held until clear or reset.
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.clear) begin
            state_d      = IDLE;
            pill_cnt_d   = '0;
            bottle_cnt_d = '0;
            timer_d      = '0;
            cfg_err_d    = 1'b0;
        end

        valve_d = (state_d == FILL) && !bus.pause;
        conv_d  = (state_d == ADVANCE) && !bus.pause;
        full_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            pill_sync_q  <= '0;
            pill_cnt_q   <= '0;
            bottle_cnt_q <= '0;
            ppb_q        <= '0;
            tgt_q        <= '0;
            timer_q      <= '0;
            cfg_err_q    <= 1'b0;
            valve_q      <= 1'b0;
            conv_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pill_sync_q  <= {pill_sync_q[1:0], bus.pill_in};
            pill_cnt_q   <= pill_cnt_d;
            bottle_cnt_q <= bottle_cnt_d;
            ppb_q        <= ppb_d;
            tgt_q        <= tgt_d;
            timer_q      <= timer_d;
            cfg_err_q    <= cfg_err_d;
            valve_q      <= valve_d;
            conv_q       <= conv_d;
            full_q       <= full_d;
        end
    end

    assign bus.valve_open   = valve_q;
    assign bus.conveyor_run = conv_q;
    assign bus.pill_cnt     = pill_cnt_q;
    assign bus.bottle_cnt   = bottle_cnt_q;
    assign bus.allFull      = full_q;
    assign bus.cfg_err      = cfg_err_q;

endmodule
